imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the MIPS32 pipeline fetches from. It accepts a byte stream carrying a load image: header, instruction words, checksum. It writes each assembled word into instruction memory and holds the core in reset while loading. When the checksum verifies, it releases the core with `startPC` set to the image base address. It sits between the host byte link and the `instr_mem` write port, and drives the core's `reset` and `startPC`.

---
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream (base, count, words,
// checksum) into instruction-memory writes and holds the core in reset until
// the image has been verified.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic [31:0]       start_pc,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    HDR_ADDR,
    HDR_CNT,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  state_t      state;
  logic [1:0]  bcnt;
  logic [23:0] sh;
  logic [31:0] base;
  logic [31:0] num;
  logic [31:0] idx;
  logic [7:0]  sum;
  logic        rdy;
  logic        we;

  logic        accept;
  logic [31:0] word;
  logic [7:0]  sum_nxt;
  logic [32:0] span;

  // A restart or reset in the current cycle blocks the byte and any pending write.
  assign s_ready = rdy & ~load_start & ~reset;
  assign imem_we = we & ~load_start & ~reset;
  assign accept  = s_valid & s_ready;
  assign word    = {sh, s_data};
  assign sum_nxt = sum + s_data;
  assign span    = {1'b0, base} + {1'b0, word};

  // Load FSM with field assembly, running checksum and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR_ADDR;
      bcnt       <= 2'd0;
      idx        <= 32'd0;
      sum        <= 8'd0;
      rdy        <= 1'b0;
      we         <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b1;
      start_pc   <= 32'd0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (load_start) begin
      state      <= HDR_ADDR;
      bcnt       <= 2'd0;
      idx        <= 32'd0;
      sum        <= 8'd0;
      rdy        <= 1'b0;
      we         <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      we <= 1'b0;
      if (state == HDR_ADDR || state == HDR_CNT || state == DATA || state == CSUM)
        rdy <= 1'b1;
      if (accept) begin
        sum  <= sum_nxt;
        sh   <= {sh[15:0], s_data};
        bcnt <= 2'(bcnt + 2'd1);
        case (state)
          HDR_ADDR: begin
            if (bcnt == 2'd3) begin
              base  <= word;
              state <= HDR_CNT;
            end
          end
          HDR_CNT: begin
            if (bcnt == 2'd3) begin
              num <= word;
              // 33-bit span check: the image must fit without wrapping.
              if (word != 32'd0 && span <= DEPTH) begin
                state <= DATA;
              end else begin
                state    <= ERR;
                rdy      <= 1'b0;
                load_err <= 1'b1;
              end
            end
          end
          DATA: begin
            if (bcnt == 2'd3) begin
              we         <= 1'b1;
              imem_waddr <= base[ADDR_W-1:0] + idx[ADDR_W-1:0];
              imem_wdata <= word;
              idx        <= idx + 32'd1;
              if (idx == num - 32'd1)
                state <= CSUM;
            end
          end
          CSUM: begin
            rdy <= 1'b0;
            if (sum_nxt == 8'd0) begin
              state      <= RUN;
              core_reset <= 1'b0;
              load_done  <= 1'b1;
              start_pc   <= 32'(base[ADDR_W-1:0]);
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader with a write logger.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic [31:0]       start_pc;
  logic              load_done;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .start_pc   (start_pc),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  int                dbl = 0;
  logic              prev_we = 1'b0;
  logic [7:0]        img[$];

  // Log every write seen mid-cycle and count back-to-back strobes.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_waddr);
      wd.push_back(imem_wdata);
      if (prev_we) dbl <= dbl + 1;
    end
    prev_we <= imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    repeat (gap) step();
  endtask

  task automatic send_img(input int gap);
    for (int i = 0; i < img.size(); i++) send(img[i], gap);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  int base_n;

  initial begin
    reset = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    step();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_start_pc", start_pc, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    reset = 1'b0;

    // Test 1: nominal load
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    send_img(0);
    check("t1_core_reset_before_csum", 32'(core_reset), 32'd1);
    send(8'hC8, 0);
    check("t1_core_reset", 32'(core_reset), 32'd0);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_err", 32'(load_err), 32'd0);
    check("t1_start_pc", start_pc, 32'h10);
    check("t1_s_ready", 32'(s_ready), 32'd0);
    step();
    check("t1_nwrites", 32'(wa.size() - base_n), 32'd2);
    if (wa.size() - base_n == 2) begin
      check("t1_w0_addr", 32'(wa[base_n]), 32'h10);
      check("t1_w0_data", wd[base_n], 32'h20010005);
      check("t1_w1_addr", 32'(wa[base_n+1]), 32'h11);
      check("t1_w1_data", wd[base_n+1], 32'h0);
    end

    // Test 6a: reload from RUN
    pulse_start();
    check("t6_core_reset", 32'(core_reset), 32'd1);
    check("t6_done", 32'(load_done), 32'd0);
    check("t6_s_ready_first", 32'(s_ready), 32'd0);
    check("t6_start_pc_kept", start_pc, 32'h10);
    step();
    check("t6_s_ready", 32'(s_ready), 32'd1);

    // Test 2: bad checksum
    base_n = wa.size();
    send_img(0);
    send(8'hC7, 0);
    step();
    check("t2_err", 32'(load_err), 32'd1);
    check("t2_core_reset", 32'(core_reset), 32'd1);
    check("t2_done", 32'(load_done), 32'd0);
    check("t2_s_ready", 32'(s_ready), 32'd0);
    check("t2_nwrites", 32'(wa.size() - base_n), 32'd2);

    // Test 3a: N = 0
    pulse_start();
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_img(0);
    check("t3a_err", 32'(load_err), 32'd1);
    check("t3a_s_ready", 32'(s_ready), 32'd0);
    step();
    check("t3a_nwrites", 32'(wa.size() - base_n), 32'd0);

    // Test 3b: B = 0xFF, N = 2 overflows
    pulse_start();
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
    send_img(0);
    check("t3b_err", 32'(load_err), 32'd1);
    step();
    check("t3b_nwrites", 32'(wa.size() - base_n), 32'd0);

    // Test 3c: B = 0xFE, N = 2 fills to the top word
    pulse_start();
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_img(0);
    check("t3c_done", 32'(load_done), 32'd1);
    check("t3c_err", 32'(load_err), 32'd0);
    check("t3c_start_pc", start_pc, 32'hFE);
    step();
    check("t3c_nwrites", 32'(wa.size() - base_n), 32'd2);
    if (wa.size() - base_n == 2) begin
      check("t3c_w0_addr", 32'(wa[base_n]), 32'hFE);
      check("t3c_w1_addr", 32'(wa[base_n+1]), 32'hFF);
    end

    // Test 4: nominal image with 3-cycle gaps
    pulse_start();
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC8};
    send_img(3);
    check("t4_done", 32'(load_done), 32'd1);
    check("t4_core_reset", 32'(core_reset), 32'd0);
    check("t4_start_pc", start_pc, 32'h10);
    check("t4_nwrites", 32'(wa.size() - base_n), 32'd2);
    if (wa.size() - base_n == 2) begin
      check("t4_w0_addr", 32'(wa[base_n]), 32'h10);
      check("t4_w0_data", wd[base_n], 32'h20010005);
      check("t4_w1_addr", 32'(wa[base_n+1]), 32'h11);
      check("t4_w1_data", wd[base_n+1], 32'h0);
    end

    // Test 5: abort after the 2nd data byte, then a fresh image
    pulse_start();
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01};
    send_img(0);
    pulse_start();
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h12, 8'h34, 8'h56, 8'h78, 8'hEB};
    send_img(0);
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_start_pc", start_pc, 32'h0);
    step();
    check("t5_nwrites", 32'(wa.size() - base_n), 32'd1);
    if (wa.size() - base_n == 1) begin
      check("t5_w0_addr", 32'(wa[base_n]), 32'h00);
      check("t5_w0_data", wd[base_n], 32'h12345678);
    end

    // Restart in the cycle a write is presented suppresses it
    pulse_start();
    base_n = wa.size();
    img = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h20, 8'h01, 8'h00, 8'h05};
    send_img(0);
    load_start = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h00;
    #1;
    check("abort_we_suppressed", 32'(imem_we), 32'd0);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    s_valid = 1'b0;
    step();
    check("abort_nwrites", 32'(wa.size() - base_n), 32'd0);
    check("abort_core_reset", 32'(core_reset), 32'd1);

    // Test 6b: reset mid-DATA
    img = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC8};
    send_img(0);
    check("t6b_start_pc_before", start_pc, 32'h10);
    pulse_start();
    img = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01};
    send_img(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6b_start_pc", start_pc, 32'h0);
    check("t6b_core_reset", 32'(core_reset), 32'd1);
    check("t6b_done", 32'(load_done), 32'd0);
    check("t6b_s_ready_first", 32'(s_ready), 32'd0);
    step();
    check("t6b_s_ready", 32'(s_ready), 32'd1);

    check("no_back_to_back_we", 32'(dbl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
